// File: rtl/nn_layer_sequencer_if.sv
// Handshake and vector bus between the layer sequencer, its upstream/downstream
// ports and the chain of layer instances it drives.
interface nn_layer_sequencer_if #(
  parameter int BIT_WIDTH  = 32,
  parameter int MAX_WIDTH  = 5,
  parameter int NUM_LAYERS = 3
);
  localparam int VecWidth = MAX_WIDTH * BIT_WIDTH;

  logic                           in_valid;
  logic                           in_ready;
  logic [VecWidth-1:0]            in_data;
  logic [NUM_LAYERS-1:0]          layer_start;
  logic [NUM_LAYERS-1:0]          layer_done;
  logic [VecWidth-1:0]            layer_in;
  logic [NUM_LAYERS*VecWidth-1:0] layer_out;
  logic                           out_valid;
  logic                           out_ready;
  logic [VecWidth-1:0]            out_data;

  modport master (
    input  in_valid, in_data, layer_done, layer_out, out_ready,
    output in_ready, layer_start, layer_in, out_valid, out_data
  );

  modport slave (
    output in_valid, in_data, layer_done, layer_out, out_ready,
    input  in_ready, layer_start, layer_in, out_valid, out_data
  );
endinterface

// File: rtl/nn_layer_sequencer.sv
// Runs one inference through NUM_LAYERS layers: start pulse, edge-qualified done,
// capture into a single ping buffer, per-layer watchdog, final vector handshake.
module nn_layer_sequencer #(
  parameter int BIT_WIDTH      = 32,
  parameter int FRACTION_WIDTH = 15,
  parameter int NUM_LAYERS     = 3,
  parameter int MAX_WIDTH      = 5,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 soft_clr,
  nn_layer_sequencer_if.master bus,
  output logic                 busy,
  output logic [2:0]           cur_layer,
  output logic                 error
);
  localparam int VecWidth   = MAX_WIDTH * BIT_WIDTH;
  localparam int TimerWidth = $clog2(TIMEOUT_CYCLES);
  localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] LastLayer = 3'(NUM_LAYERS - 1);
  localparam logic [NUM_LAYERS-1:0] FirstStart = NUM_LAYERS'(1);

  if (NUM_LAYERS < 1 || NUM_LAYERS > 8 || TIMEOUT_CYCLES < 2 ||
      FRACTION_WIDTH < 0 || FRACTION_WIDTH >= BIT_WIDTH) begin : g_bad_params
    $error("nn_layer_sequencer: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, START, WAIT, CAPTURE, OUTPUT, ERROR} state_t;

  state_t                  state_q;
  logic [VecWidth-1:0]     buf_q;
  logic [2:0]              cur_layer_q;
  logic [TimerWidth-1:0]   timer_q;
  logic                    armed_q;
  logic [NUM_LAYERS-1:0]   start_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic                    busy_q;
  logic                    error_q;

  logic                    done_sel;
  logic [VecWidth-1:0]     capture_vec;
  logic [2:0]              next_layer_d;
  logic [NUM_LAYERS-1:0]   next_start_d;

  // Only the active layer's done and output slice are ever looked at.
  always_comb begin
    done_sel    = 1'b0;
    capture_vec = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (cur_layer_q == 3'(k)) begin
        done_sel    = bus.layer_done[k];
        capture_vec = bus.layer_out[k*VecWidth +: VecWidth];
      end
    end
  end

  assign next_layer_d = cur_layer_q + 3'd1;

  always_comb begin
    next_start_d = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      next_start_d[k] = (next_layer_d == 3'(k));
    end
  end

  // Outputs are registered alongside the state transition so each one is
  // valid for exactly the cycles the matching state is occupied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      cur_layer_q <= '0;
      timer_q     <= '0;
      armed_q     <= 1'b0;
      start_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      start_q <= '0;
      if (soft_clr) begin
        state_q     <= IDLE;
        timer_q     <= '0;
        armed_q     <= 1'b0;
        in_ready_q  <= 1'b1;
        out_valid_q <= 1'b0;
        busy_q      <= 1'b0;
        error_q     <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.in_valid) begin
              buf_q       <= bus.in_data;
              cur_layer_q <= '0;
              start_q     <= FirstStart;
              state_q     <= START;
              in_ready_q  <= 1'b0;
              busy_q      <= 1'b1;
            end
          end
          START: begin
            timer_q <= '0;
            armed_q <= 1'b0;
            state_q <= WAIT;
          end
          WAIT: begin
            // A done that was already high when the layer started must drop
            // once before it can count, so stale level dones are ignored.
            if (armed_q && done_sel) begin
              state_q <= CAPTURE;
            end else begin
              if (!done_sel) begin
                armed_q <= 1'b1;
              end
              if (timer_q == TimerLast) begin
                state_q <= ERROR;
                error_q <= 1'b1;
              end else begin
                timer_q <= timer_q + 1'b1;
              end
            end
          end
          CAPTURE: begin
            buf_q <= capture_vec;
            if (cur_layer_q == LastLayer) begin
              state_q     <= OUTPUT;
              out_valid_q <= 1'b1;
            end else begin
              cur_layer_q <= next_layer_d;
              start_q     <= next_start_d;
              state_q     <= START;
            end
          end
          OUTPUT: begin
            if (bus.out_ready) begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
            end
          end
          ERROR: begin
            state_q <= ERROR;
          end
          default: begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.layer_start = start_q;
  assign bus.layer_in    = buf_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = buf_q;
  assign busy            = busy_q;
  assign cur_layer       = cur_layer_q;
  assign error           = error_q;
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer: layer models with configurable done
// behaviour, scoreboard of expected final vectors, cycle-accurate latency checks.
module tb_nn_layer_sequencer;
  localparam int BW = 32;
  localparam int MW = 5;
  localparam int NL = 3;
  localparam int TO = 16;
  localparam int VW = MW * BW;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       soft_clr = 1'b0;
  logic       busy;
  logic [2:0] cur_layer;
  logic       error;

  nn_layer_sequencer_if #(.BIT_WIDTH(BW), .MAX_WIDTH(MW), .NUM_LAYERS(NL)) bus ();

  nn_layer_sequencer #(
    .BIT_WIDTH(BW), .FRACTION_WIDTH(15), .NUM_LAYERS(NL),
    .MAX_WIDTH(MW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .soft_clr(soft_clr), .bus(bus),
    .busy(busy), .cur_layer(cur_layer), .error(error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [VW-1:0] sb[$];

  // Layer model modes: 0 = done at start+4 (held), 1 = stale high, low at +3, high at +5, 2 = never done
  int mode[NL] = '{default: 0};
  int cnt[NL]  = '{default: 1000};

  function automatic logic doneFor(input int m, input int c);
    case (m)
      0:       return (c >= 4);
      1:       return (c <= 2) || (c >= 5);
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < NL; k++) begin
      if (bus.layer_start[k] === 1'b1) cnt[k] = 0;
      else if (cnt[k] < 1000) cnt[k] = cnt[k] + 1;
      bus.layer_done[k] = doneFor(mode[k], cnt[k]);
    end
  end

  function automatic logic [VW-1:0] patVec(input int k);
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < MW; i++) v[i*BW +: BW] = 32'(k * 16 + i);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [VW-1:0] observed, input logic [VW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [VW-1:0] vec);
    bus.in_data  = vec;
    bus.in_valid = 1'b1;
    sb.push_back(bus.layer_out[(NL-1)*VW +: VW]);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic trackRun(output int s0, output int s1, output int s2, output int v, output logic busyOk);
    int  rel;
    bit  fin;
    rel = 1; fin = 0;
    s0 = -1; s1 = -1; s2 = -1; v = -1; busyOk = 1'b1;
    while (!fin && rel <= 80) begin
      if (bus.layer_start[0] === 1'b1) s0 = rel;
      if (bus.layer_start[1] === 1'b1) s1 = rel;
      if (bus.layer_start[2] === 1'b1) s2 = rel;
      if (busy !== 1'b1) busyOk = 1'b0;
      if (bus.out_valid === 1'b1) begin
        v = rel;
        fin = 1;
      end else begin
        tick();
        rel++;
      end
    end
  endtask

  task automatic expectFinal(input string tag);
    checkOutput({tag, "_sb_nonempty"}, VW'(sb.size() != 0), VW'(1));
    if (sb.size() != 0) checkOutput(tag, bus.out_data, sb.pop_front());
  endtask

  task automatic finishOutput(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, VW'(bus.out_valid), VW'(0));
    checkOutput({tag, "_in_ready"}, VW'(bus.in_ready), VW'(1));
    checkOutput({tag, "_busy_low"}, VW'(busy), VW'(0));
  endtask

  int s0, s1, s2, v;
  logic busyOk;
  logic [VW-1:0] inVec, inVec2, nzVec, nomFinal;
  bit sawStart, sawBusy;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < NL; k++) bus.layer_out[k*VW +: VW] = patVec(k);
    for (int i = 0; i < MW; i++) begin
      inVec[i*BW +: BW]  = 32'hA000_0000 + 32'(i);
      inVec2[i*BW +: BW] = 32'h0B00_0000 + 32'(i);
    end
    nzVec = {32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 32'h8000_0001, 32'h8000_0000};
    nomFinal = patVec(2);

    // Reset state
    #1 rst = 1'b1;
    #11;
    checkOutput("reset_busy", VW'(busy), VW'(0));
    checkOutput("reset_start", VW'(bus.layer_start), VW'(0));
    checkOutput("reset_out_valid", VW'(bus.out_valid), VW'(0));
    checkOutput("reset_error", VW'(error), VW'(0));
    checkOutput("reset_cur_layer", VW'(cur_layer), VW'(0));
    checkOutput("reset_layer_in", bus.layer_in, VW'(0));
    #5 rst = 1'b0;
    tick();
    checkOutput("in_ready_after_reset", VW'(bus.in_ready), VW'(1));

    // Nominal run
    applyStimulus(inVec);
    checkOutput("nom_first_start", VW'(bus.layer_start), VW'(3'b001));
    checkOutput("nom_layer_in", bus.layer_in, inVec);
    checkOutput("nom_in_ready_low", VW'(bus.in_ready), VW'(0));
    trackRun(s0, s1, s2, v, busyOk);
    checkOutput("nom_start0", VW'(s0), VW'(1));
    checkOutput("nom_start1", VW'(s1), VW'(7));
    checkOutput("nom_start2", VW'(s2), VW'(13));
    checkOutput("nom_out_valid_cycle", VW'(v), VW'(19));
    checkOutput("nom_busy", VW'(busyOk), VW'(1));
    expectFinal("nom_out_data");

    // Backpressure, with the next run's last layer producing sign/negative-zero patterns
    bus.layer_out[(NL-1)*VW +: VW] = nzVec;
    bus.in_data  = inVec2;
    bus.in_valid = 1'b1;
    sb.push_back(nzVec);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("bp_out_data_%0d", i), bus.out_data, nomFinal);
      checkOutput($sformatf("bp_in_ready_%0d", i), VW'(bus.in_ready), VW'(0));
      checkOutput($sformatf("bp_out_valid_%0d", i), VW'(bus.out_valid), VW'(1));
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checkOutput("bp_idle_in_ready", VW'(bus.in_ready), VW'(1));
    checkOutput("bp_idle_out_valid", VW'(bus.out_valid), VW'(0));
    checkOutput("bp_idle_no_start", VW'(bus.layer_start), VW'(0));
    tick();
    bus.in_valid = 1'b0;
    checkOutput("bp_accept_start", VW'(bus.layer_start), VW'(3'b001));
    checkOutput("bp_accept_layer_in", bus.layer_in, inVec2);
    trackRun(s0, s1, s2, v, busyOk);
    checkOutput("nz_out_valid_cycle", VW'(v), VW'(19));
    expectFinal("nz_out_data");
    finishOutput("nz_done");

    // Stale level done on layer 1
    mode[1] = 1;
    applyStimulus(inVec);
    trackRun(s0, s1, s2, v, busyOk);
    checkOutput("stale_start1", VW'(s1), VW'(7));
    checkOutput("stale_start2", VW'(s2), VW'(14));
    checkOutput("stale_out_valid_cycle", VW'(v), VW'(20));
    expectFinal("stale_out_data");
    finishOutput("stale_done");

    // Watchdog timeout on layer 1
    mode[1] = 2;
    applyStimulus(inVec);
    for (int i = 0; i < 22; i++) tick();
    checkOutput("to_last_wait_error", VW'(error), VW'(0));
    checkOutput("to_last_wait_layer", VW'(cur_layer), VW'(1));
    tick();
    checkOutput("to_error", VW'(error), VW'(1));
    checkOutput("to_in_ready", VW'(bus.in_ready), VW'(0));
    checkOutput("to_out_valid", VW'(bus.out_valid), VW'(0));
    checkOutput("to_busy", VW'(busy), VW'(1));
    soft_clr = 1'b1;
    tick();
    checkOutput("clr_error", VW'(error), VW'(0));
    checkOutput("clr_in_ready", VW'(bus.in_ready), VW'(1));
    bus.in_valid = 1'b1;
    tick();
    checkOutput("clr_priority_no_start", VW'(bus.layer_start), VW'(0));
    checkOutput("clr_priority_busy", VW'(busy), VW'(0));
    soft_clr = 1'b0;
    bus.in_valid = 1'b0;
    sb.delete();
    tick();

    // Asynchronous reset during layer 1 WAIT
    mode[1] = 0;
    applyStimulus(inVec);
    for (int i = 0; i < 8; i++) tick();
    checkOutput("ar_pre_layer", VW'(cur_layer), VW'(1));
    #2 rst = 1'b1;
    #1;
    checkOutput("ar_busy", VW'(busy), VW'(0));
    checkOutput("ar_start", VW'(bus.layer_start), VW'(0));
    checkOutput("ar_out_valid", VW'(bus.out_valid), VW'(0));
    checkOutput("ar_error", VW'(error), VW'(0));
    checkOutput("ar_cur_layer", VW'(cur_layer), VW'(0));
    checkOutput("ar_layer_in", bus.layer_in, VW'(0));
    sb.delete();
    #20 rst = 1'b0;
    sawStart = 0;
    sawBusy  = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.layer_start !== '0) sawStart = 1;
      if (busy !== 1'b0) sawBusy = 1;
    end
    checkOutput("ar_no_start_after", VW'(sawStart), VW'(0));
    checkOutput("ar_idle_after", VW'(sawBusy), VW'(0));
    applyStimulus(inVec2);
    trackRun(s0, s1, s2, v, busyOk);
    checkOutput("ar_rerun_cycle", VW'(v), VW'(19));
    expectFinal("ar_rerun_data");
    finishOutput("ar_rerun_done");

    checkOutput("sb_drained", VW'(sb.size()), VW'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end
endmodule

// File: doc/nn_layer_sequencer.md
Name: nn_layer_sequencer

Overview:
- Top-level controller that runs one inference through a chain of NUM_LAYERS fully-connected layer instances (input, hidden, output).
- Accepts one input vector per inference over a valid/ready handshake.
- Pulses each layer's start in turn and waits for that layer's done. Captures the layer's output vector into a ping buffer that feeds the next layer.
- Presents the final layer's vector downstream over valid/ready. Includes a per-layer timeout watchdog.

Parameters:
- BIT_WIDTH, 32, width of one fixed-point element (sign-magnitude, MSB = sign).
- FRACTION_WIDTH, 15, fractional bits. Carried through for consistency; no arithmetic is performed on data.
- NUM_LAYERS, 3, number of layers sequenced (1..8).
- MAX_WIDTH, 5, elements per vector bus; the widest layer input or output.
- TIMEOUT_CYCLES, 1024, WAIT cycles allowed per layer before error (>=2).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- soft_clr  in  1  synchronous abort/clear; returns FSM to IDLE.
- in_valid  in  1  upstream input vector valid.
- in_ready  out  1  sequencer can accept an input vector.
- in_data  in  MAX_WIDTH*BIT_WIDTH  input vector; element i at bits [i*BIT_WIDTH +: BIT_WIDTH].
- layer_start  out  NUM_LAYERS  one-cycle start pulse, one bit per layer.
- layer_done  in  NUM_LAYERS  done flag from each layer (level or pulse).
- layer_in  out  MAX_WIDTH*BIT_WIDTH  vector driven to the active layer (the buffer).
- layer_out  in  NUM_LAYERS*MAX_WIDTH*BIT_WIDTH  all layer outputs; layer k at slice k*MAX_WIDTH*BIT_WIDTH.
- out_valid  out  1  final vector valid.
- out_ready  in  1  downstream accepts final vector.
- out_data  out  MAX_WIDTH*BIT_WIDTH  final vector (equals buffer).
- busy  out  1  high in every state except IDLE.
- cur_layer  out  3  index of the layer being started, waited on or captured.
- error  out  1  sticky timeout flag.

Behaviour:
- Reset (rst=1, async):
  - State returns to IDLE.
  - Buffer, cur_layer, timer and armed all clear to 0.
  - Outputs: layer_start=0, out_valid=0, error=0, busy=0, in_ready=1 once released.
  - Reset mid-inference abandons the run; no start pulse is issued afterwards.
- State machine, states IDLE, START, WAIT, CAPTURE, OUTPUT, ERROR:
  - IDLE: in_ready=1. On in_valid=1, the buffer takes in_data, cur_layer=0, and the FSM goes to START.
  - START: layer_start[cur_layer]=1 for exactly this cycle. Timer and armed clear to 0. Next state is WAIT.
  - WAIT:
    - If layer_done[cur_layer]=0, set armed=1.
    - If armed=1 and layer_done[cur_layer]=1, go to CAPTURE.
    - Otherwise increment timer. When the timer reaches TIMEOUT_CYCLES-1 without a qualified done, go to ERROR.
    - Edge qualification means a level done still high from a previous run is never accepted. Done is never accepted in the START cycle.
  - CAPTURE: the buffer takes the layer_out slice for cur_layer. If cur_layer=NUM_LAYERS-1 go to OUTPUT; otherwise increment cur_layer and go to START.
  - OUTPUT: out_valid=1 and out_data=buffer, both held stable until out_ready=1. Then go to IDLE.
  - ERROR: error=1, in_ready=0, out_valid=0. The FSM stays here until soft_clr.
- soft_clr:
  - From any state, soft_clr goes to IDLE next cycle and clears error, timer and armed.
  - The buffer is not cleared.
  - soft_clr has priority over every other transition, including in_valid in IDLE.
- layer_in equals the buffer at all times. It is stable from START through the end of WAIT.
- Only layer_done[cur_layer] is observed; done bits of other layers are ignored.
- in_ready=0 in all states except IDLE. An in_valid arriving in OUTPUT is accepted only after the return to IDLE, never in the same cycle as out_ready.
- Latency: if a layer raises done D cycles after its start cycle (D>=2, done low at start+1), that layer occupies D+2 cycles. Input acceptance to out_valid is NUM_LAYERS*(D+2)+1 cycles.
- No data arithmetic: vectors pass bit-exact. Sign-magnitude encodings, including negative zero, are preserved.

Test Plan:
- Nominal run:
  - Stimulus: NUM_LAYERS=3; layer models drive done low, then high at start+4; layer k returns element i = k*16+i. Accept the input at cycle 0.
  - Required: start pulses at cycles 1, 7 and 13; out_valid at cycle 19; out_data element i = 32+i; busy high from cycle 1 to cycle 19.
- Stale level done:
  - Stimulus: hold layer_done[1] high continuously until start+3, then low at start+3 and high at start+5.
  - Required: capture occurs only after start+5; the stale high is not accepted.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16; layer 1 never asserts done.
  - Required: error=1 after 16 WAIT cycles; in_ready=0. Pulse soft_clr; error=0 and in_ready=1 on the next cycle.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles with in_valid=1 throughout.
  - Required: out_data stable and in_ready=0 throughout. After out_ready=1, the next input is accepted exactly one cycle later.
- Async reset mid-run:
  - Stimulus: assert rst during WAIT of layer 1, not aligned to clk.
  - Required: outputs go to their reset values immediately. No further layer_start pulse after rst is released until a new in_valid.
- Negative-zero and sign pass-through:
  - Stimulus: layer outputs 32'h8000_0000 and 32'h8000_0001.
  - Required: out_data reproduces both values bit-exact.
